// File: rtl/midi_note_period_gen.sv
// Multi-voice MIDI note -> sample-tick period converter with sequential /12 and per-voice portamento.
// Accepts one request at a time (note_ready low while converting); glide runs on every tick_en.
module midi_note_period_gen #(
  parameter int NUM_VOICES = 4,
  parameter int TICK_W     = 24,
  localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic [VOICE_W-1:0]           note_voice,
  input  logic [7:0]                   note_num,
  input  logic [3:0]                   glide_shift,
  input  logic                         tick_en,
  output logic                         note_done,
  output logic                         note_err,
  output logic [NUM_VOICES*TICK_W-1:0] period
);

  typedef enum logic [1:0] {S_IDLE, S_ERR, S_DIV, S_WRITE} state_t;

  state_t               state, state_nx;
  logic [VOICE_W-1:0]   voice;
  logic [6:0]           rem;
  logic [3:0]           oct;
  logic                 bad_req;
  logic [TICK_W-1:0]    wr_val;
  logic [TICK_W-1:0]    tgt [NUM_VOICES];
  logic [TICK_W-1:0]    cur [NUM_VOICES];

  // Octave-0 periods for semitones C..B.
  function automatic logic [13:0] base_lut(input logic [3:0] s);
    case (s)
      4'd0:    base_lut = 14'd11944;
      4'd1:    base_lut = 14'd11274;
      4'd2:    base_lut = 14'd10641;
      4'd3:    base_lut = 14'd10044;
      4'd4:    base_lut = 14'd9480;
      4'd5:    base_lut = 14'd8948;
      4'd6:    base_lut = 14'd8446;
      4'd7:    base_lut = 14'd7972;
      4'd8:    base_lut = 14'd7524;
      4'd9:    base_lut = 14'd7102;
      4'd10:   base_lut = 14'd6703;
      4'd11:   base_lut = 14'd6327;
      default: base_lut = 14'd0;
    endcase
  endfunction

  // Step is diff>>shift (min 1), which is never larger than diff, so no overshoot.
  function automatic logic [TICK_W-1:0] glide_next(input logic [TICK_W-1:0] c,
                                                   input logic [TICK_W-1:0] t,
                                                   input logic [3:0]        sh);
    logic [TICK_W-1:0] d;
    logic [TICK_W-1:0] s;
    d = (t > c) ? (t - c) : (c - t);
    s = d >> sh;
    if (s == '0) s = TICK_W'(1);
    if (c == t)                   glide_next = c;
    else if (c == '0 || sh == '0) glide_next = t;
    else if (t > c)               glide_next = c + s;
    else                          glide_next = c - s;
  endfunction

  assign bad_req = note_num[7] || (32'(note_voice) >= NUM_VOICES);
  assign wr_val  = TICK_W'(base_lut(rem[3:0])) >> oct;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    note_ready = 1'b0;
    note_done  = 1'b0;
    note_err   = 1'b0;
    case (state)
      S_IDLE: begin
        note_ready = 1'b1;
        if (note_valid) state_nx = bad_req ? S_ERR : S_DIV;
      end
      S_ERR: begin
        note_err = 1'b1;
        state_nx = S_IDLE;
      end
      S_DIV: begin
        if (rem < 7'd12) state_nx = S_WRITE;
      end
      S_WRITE: begin
        note_done = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice <= '0;
      rem   <= '0;
      oct   <= '0;
    end else if (state == S_IDLE && note_valid) begin
      voice <= note_voice;
      rem   <= note_num[6:0];
      oct   <= '0;
    end else if (state == S_DIV && rem >= 7'd12) begin
      rem <= rem - 7'd12;
      oct <= oct + 4'd1;
    end
  end

  // Glide reads the pre-edge target, so a same-edge write applies from the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        tgt[v] <= '0;
        cur[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (state == S_WRITE && voice == VOICE_W'(v)) tgt[v] <= wr_val;
        if (tick_en) cur[v] <= glide_next(cur[v], tgt[v], glide_shift);
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign period[g*TICK_W +: TICK_W] = cur[g];
  end

endmodule

// File: tb/tb_midi_note_period_gen.sv
// Bench for midi_note_period_gen: vector table plus glide, error, back-to-back and reset sequences.
module tb_midi_note_period_gen;
  localparam int NV = 5;
  localparam int TW = 24;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          note_valid;
  logic          note_ready;
  logic [VW-1:0] note_voice;
  logic [7:0]    note_num;
  logic [3:0]    glide_shift;
  logic          tick_en;
  logic          note_done;
  logic          note_err;
  logic [NV*TW-1:0] period;

  midi_note_period_gen #(.NUM_VOICES(NV), .TICK_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
    .note_voice(note_voice), .note_num(note_num), .glide_shift(glide_shift),
    .tick_en(tick_en), .note_done(note_done), .note_err(note_err), .period(period)
  );

  always #5 clk = ~clk;

  typedef struct {int voice; int note; int per; int lat;} vec_t;
  typedef struct {int voice; int lat;} exp_t;

  vec_t tbl [5];
  exp_t exp_q [$];
  exp_t me;
  int   errors = 0, checks = 0;
  int   cyc = 0, acc_cyc = 0, last_done = 0, done_cnt = 0, err_cnt = 0;
  int   mdl [NV];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int per_of(input int v);
    return int'(period[v*TW +: TW]);
  endfunction

  task automatic check_all(input string tag);
    for (int v = 0; v < NV; v++) chk($sformatf("%s_v%0d", tag, v), per_of(v), mdl[v]);
  endtask

  // Scoreboard side: accept time is captured on the accepting edge, done latency checked on pop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && note_valid && note_ready) acc_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (note_err) err_cnt++;
    if (note_done) begin
      done_cnt++;
      last_done = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = exp_q.pop_front();
        chk($sformatf("done_latency_v%0d", me.voice), cyc - acc_cyc + 1, me.lat);
      end
    end
  end

  task automatic send(input int v, input int n);
    @(negedge clk);
    note_voice = VW'(v);
    note_num   = 8'(n);
    note_valid = 1'b1;
    for (int k = 0; k < 100 && !note_ready; k++) @(negedge clk);
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && note_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic tick(input int g);
    @(negedge clk);
    tick_en     = 1'b1;
    glide_shift = 4'(g);
    @(negedge clk);
    tick_en = 1'b0;
    #1;
  endtask

  initial begin
    int cur, tg, d, s, bd, be, low;
    int ref4 [4];
    ref4 = '{466, 536, 588, 627};
    tbl[0] = '{0, 69, 221, 7};
    tbl[1] = '{1, 0, 11944, 2};
    tbl[2] = '{2, 12, 5972, 3};
    tbl[3] = '{3, 127, 7, 12};
    tbl[4] = '{4, 60, 373, 7};
    for (int v = 0; v < NV; v++) mdl[v] = 0;

    rst_n = 1'b0; note_valid = 1'b0; note_voice = '0; note_num = '0;
    glide_shift = '0; tick_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(note_ready), 1);
    chk("reset_done", int'(note_done), 0);
    chk("reset_err", int'(note_err), 0);
    check_all("reset_period");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{tbl[i].voice, tbl[i].lat});
      send(tbl[i].voice, tbl[i].note);
      wait_idle("table");
      tick(0);
      mdl[tbl[i].voice] = tbl[i].per;
      check_all($sformatf("table%0d", i));
    end

    // Portamento 373 -> 746 at shift 2.
    exp_q.push_back('{0, 7});
    send(0, 60);
    wait_idle("glide_a");
    tick(0);
    mdl[0] = 373;
    check_all("glide_start");
    exp_q.push_back('{0, 6});
    send(0, 48);
    wait_idle("glide_b");
    cur = 373; tg = 746; s = 0;
    for (int k = 0; k < 60 && cur != tg; k++) begin
      d = tg - cur;
      s = d >> 2;
      if (s == 0) s = 1;
      cur = cur + s;
      tick(2);
      chk($sformatf("glide_tick%0d", k), per_of(0), cur);
      if (k < 4) chk($sformatf("glide_ref%0d", k), per_of(0), ref4[k]);
    end
    chk("glide_final", per_of(0), 746);
    chk("glide_last_step", s, 1);
    mdl[0] = 746;
    tick(2);
    check_all("glide_hold");

    // Rejected requests.
    bd = done_cnt; be = err_cnt;
    send(0, 8'h80);
    repeat (3) @(negedge clk);
    send(5, 10);
    repeat (3) @(negedge clk);
    chk("err_pulses", err_cnt - be, 2);
    chk("err_no_done", done_cnt - bd, 0);
    tick(0);
    check_all("err_periods");

    // Held valid across two requests.
    exp_q.push_back('{1, 4});
    exp_q.push_back('{2, 5});
    @(negedge clk);
    note_voice = 3'd1; note_num = 8'd24; note_valid = 1'b1;
    @(negedge clk);
    note_voice = 3'd2; note_num = 8'd36;
    low = 0;
    for (int k = 0; k < 50; k++) begin
      if (note_ready) break;
      low++;
      @(negedge clk);
    end
    chk("b2b_ready_low", low, 4);
    @(negedge clk);
    note_valid = 1'b0;
    chk("b2b_gap", acc_cyc - last_done, 2);
    wait_idle("b2b");
    tick(0);
    mdl[1] = 2986; mdl[2] = 1493;
    check_all("b2b");

    // Reset during DIV.
    bd = done_cnt;
    @(negedge clk);
    note_voice = 3'd0; note_num = 8'd100; note_valid = 1'b1;
    @(negedge clk);
    note_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    for (int v = 0; v < NV; v++) mdl[v] = 0;
    chk("rst_mid_ready", int'(note_ready), 1);
    check_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - bd, 0);
    exp_q.push_back('{0, 10});
    send(0, 100);
    wait_idle("after_rst");
    tick(0);
    mdl[0] = 37;
    check_all("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
